// File: rtl/bsw_pkg.sv
// bsw_pkg: shared types and defaults for the banded Smith-Waterman
// stimulus/result engine.
package bsw_pkg;

    typedef logic [1:0] nt_t;

    localparam nt_t NT_A = 2'd0;
    localparam nt_t NT_C = 2'd1;
    localparam nt_t NT_G = 2'd2;
    localparam nt_t NT_T = 2'd3;

    localparam int BSW_LEN     = 256;
    localparam int BSW_SCORE_W = 12;
    localparam int BSW_TIMEOUT = 4096;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_WAIT
    } state_t;

endpackage

// File: rtl/bsw_seq_buf.sv
// bsw_seq_buf: query/reference base storage, one write and one read port.
// Packs S and T into one 4-bit word; contents are never reset.
module bsw_seq_buf
    import bsw_pkg::*;
#(
    parameter int LEN = BSW_LEN,
    parameter int AW  = $clog2(LEN)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  nt_t           wr_s,
    input  nt_t           wr_t,
    input  logic [AW-1:0] rd_addr,
    output nt_t           rd_s,
    output nt_t           rd_t
);

    logic [3:0] mem [LEN];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= {wr_s, wr_t};
        end
    end

    assign {rd_s, rd_t} = mem[rd_addr];

endmodule

// File: rtl/bsw_seq_streamer.sv
// bsw_seq_streamer: streams a stored S/T pair into BSW and captures max.
// Optional BSW_STREAM_CHECK_EN adds exp_max compare with pass/fail flags.
module bsw_seq_streamer
    import bsw_pkg::*;
#(
    parameter int LEN     = BSW_LEN,
    parameter int AW      = $clog2(LEN),
    parameter int SCORE_W = BSW_SCORE_W,
    parameter int TIMEOUT = BSW_TIMEOUT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  nt_t                wr_s,
    input  nt_t                wr_t,
    input  logic               start,
    output logic               busy,
    output logic               i_valid,
    output nt_t                data_s,
    output nt_t                data_t,
    input  logic               finish,
    input  logic [SCORE_W-1:0] max,
`ifdef BSW_STREAM_CHECK_EN
    input  logic [SCORE_W-1:0] exp_max,
    output logic               pass,
    output logic               fail,
`endif
    output logic [SCORE_W-1:0] result,
    output logic               done,
    output logic               timeout
);

    localparam int WDW = $clog2(TIMEOUT);
    localparam logic [AW:0]    CNT_END = (AW+1)'(LEN);
    localparam logic [WDW-1:0] WD_END  = WDW'(TIMEOUT - 1);

    state_t             state, state_nxt;
    logic [AW:0]        cnt, cnt_nxt;
    logic [WDW-1:0]     wd, wd_nxt;
    logic               busy_nxt, vld_nxt, done_nxt, tmo_nxt;
    nt_t                ds_nxt, dt_nxt, rd_s, rd_t;
    logic [SCORE_W-1:0] result_nxt;
    logic [AW-1:0]      rd_addr;
`ifdef BSW_STREAM_CHECK_EN
    logic               pass_nxt, fail_nxt;
`endif

    // Buffers are frozen for the whole run; base 0 is read while idle
    assign rd_addr = (state == ST_STREAM) ? cnt[AW-1:0] : '0;

    bsw_seq_buf #(
        .LEN (LEN),
        .AW  (AW)
    ) u_buf (
        .clk     (clk),
        .wr_en   (wr_en && (state == ST_IDLE)),
        .wr_addr (wr_addr),
        .wr_s    (wr_s),
        .wr_t    (wr_t),
        .rd_addr (rd_addr),
        .rd_s    (rd_s),
        .rd_t    (rd_t)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            wd      <= '0;
            busy    <= 1'b0;
            i_valid <= 1'b0;
            data_s  <= NT_A;
            data_t  <= NT_A;
            result  <= '0;
            done    <= 1'b0;
            timeout <= 1'b0;
`ifdef BSW_STREAM_CHECK_EN
            pass    <= 1'b0;
            fail    <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            wd      <= wd_nxt;
            busy    <= busy_nxt;
            i_valid <= vld_nxt;
            data_s  <= ds_nxt;
            data_t  <= dt_nxt;
            result  <= result_nxt;
            done    <= done_nxt;
            timeout <= tmo_nxt;
`ifdef BSW_STREAM_CHECK_EN
            pass    <= pass_nxt;
            fail    <= fail_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        wd_nxt     = wd;
        busy_nxt   = busy;
        vld_nxt    = i_valid;
        ds_nxt     = data_s;
        dt_nxt     = data_t;
        result_nxt = result;
        done_nxt   = done;
        tmo_nxt    = timeout;
`ifdef BSW_STREAM_CHECK_EN
        pass_nxt   = pass;
        fail_nxt   = fail;
`endif
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_STREAM;
                    busy_nxt  = 1'b1;
                    vld_nxt   = 1'b1;
                    ds_nxt    = rd_s;
                    dt_nxt    = rd_t;
                    cnt_nxt   = (AW+1)'(1);
                    done_nxt  = 1'b0;
                    tmo_nxt   = 1'b0;
`ifdef BSW_STREAM_CHECK_EN
                    pass_nxt  = 1'b0;
                    fail_nxt  = 1'b0;
`endif
                end
            end
            ST_STREAM: begin
                if (cnt == CNT_END) begin
                    state_nxt = ST_WAIT;
                    vld_nxt   = 1'b0;
                    ds_nxt    = NT_A;
                    dt_nxt    = NT_A;
                    wd_nxt    = '0;
                end else begin
                    ds_nxt  = rd_s;
                    dt_nxt  = rd_t;
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_WAIT: begin
                // finish takes priority over a watchdog expiry in the same cycle
                if (finish) begin
                    state_nxt  = ST_IDLE;
                    result_nxt = max;
                    done_nxt   = 1'b1;
                    busy_nxt   = 1'b0;
`ifdef BSW_STREAM_CHECK_EN
                    pass_nxt   = (max == exp_max);
                    fail_nxt   = (max != exp_max);
`endif
                end else if (wd == WD_END) begin
                    state_nxt = ST_IDLE;
                    tmo_nxt   = 1'b1;
                    busy_nxt  = 1'b0;
`ifdef BSW_STREAM_CHECK_EN
                    fail_nxt  = 1'b1;
`endif
                end else begin
                    wd_nxt = wd + 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_bsw_seq_streamer.sv
// Bench for bsw_seq_streamer: random buffers and BSW responses compared
// against a queue/array model of the stream, result and timeout rules.
module tb_bsw_seq_streamer;
    import bsw_pkg::*;

    localparam int LEN = 256;
    localparam int AW  = 8;
    localparam int SW  = 12;
    localparam int TMO = 4096;

    logic          clk     = 1'b0;
    logic          reset   = 1'b0;
    logic          wr_en   = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    nt_t           wr_s    = NT_A;
    nt_t           wr_t    = NT_A;
    logic          start   = 1'b0;
    logic          finish  = 1'b0;
    logic [SW-1:0] max     = '0;
    logic          busy, i_valid, done, timeout;
    nt_t           data_s, data_t;
    logic [SW-1:0] result;
`ifdef BSW_STREAM_CHECK_EN
    logic [SW-1:0] exp_max = '0;
    logic          pass, fail;
`endif

    nt_t           m_s [LEN];
    nt_t           m_t [LEN];
    logic [SW-1:0] m_result;
    nt_t           q_s [$];
    nt_t           q_t [$];
    int            n_seg;
    bit            prev_v;
    int            n_chk;
    int            n_fail;

    always #5 clk = ~clk;

    bsw_seq_streamer #(
        .LEN     (LEN),
        .AW      (AW),
        .SCORE_W (SW),
        .TIMEOUT (TMO)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_s    (wr_s),
        .wr_t    (wr_t),
        .start   (start),
        .busy    (busy),
        .i_valid (i_valid),
        .data_s  (data_s),
        .data_t  (data_t),
        .finish  (finish),
        .max     (max),
`ifdef BSW_STREAM_CHECK_EN
        .exp_max (exp_max),
        .pass    (pass),
        .fail    (fail),
`endif
        .result  (result),
        .done    (done),
        .timeout (timeout)
    );

    // Stream monitor: records every base presented with i_valid
    always @(negedge clk) begin
        if (i_valid) begin
            q_s.push_back(data_s);
            q_t.push_back(data_t);
            if (!prev_v) n_seg++;
        end
        prev_v = i_valid;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill(input bit plan);
        for (int i = 0; i < LEN; i++) begin
            wr_en   = 1'b1;
            wr_addr = AW'(i);
            wr_s    = plan ? nt_t'(i % 4) : nt_t'($urandom_range(3));
            wr_t    = plan ? nt_t'(3 - i % 4) : nt_t'($urandom_range(3));
            m_s[i]  = wr_s;
            m_t[i]  = wr_t;
            @(negedge clk);
        end
        wr_en = 1'b0;
    endtask

    // fin_dly > 0: finish sampled fin_dly edges after i_valid falls; 0: never
    task automatic run(input int fin_dly, input logic [SW-1:0] mx,
                       input bit poke, input int sw_addr);
        nt_t e_s [LEN];
        nt_t e_t [LEN];
        nt_t ns, nt;
        int  n, bad, lim;
        e_s = m_s;
        e_t = m_t;
        ns  = nt_t'($urandom_range(3));
        nt  = nt_t'($urandom_range(3));
        q_s.delete();
        q_t.delete();
        n_seg = 0;
`ifdef BSW_STREAM_CHECK_EN
        exp_max = ($urandom_range(1) == 1) ? mx : mx + 1'b1;
`endif
        start = 1'b1;
        if (sw_addr >= 0) begin
            wr_en       = 1'b1;
            wr_addr     = AW'(sw_addr);
            wr_s        = ns;
            wr_t        = nt;
            m_s[sw_addr] = ns;
            m_t[sw_addr] = nt;
            if (sw_addr != 0) begin
                e_s[sw_addr] = ns;
                e_t[sw_addr] = nt;
            end
        end
        @(negedge clk);
        start = 1'b0;
        wr_en = 1'b0;
        n = 0;
        while (i_valid && n < LEN + 8) begin
            start  = poke && n == 100;
            finish = poke && n == 50;
            max    = SW'($urandom);
            @(negedge clk);
            n++;
        end
        start  = 1'b0;
        finish = 1'b0;
        chk("valid_cycles", n, LEN);
        chk("stream_len", q_s.size(), LEN);
        chk("stream_segs", n_seg, 1);
        bad = 0;
        for (int i = 0; i < LEN && i < q_s.size(); i++)
            if (q_s[i] !== e_s[i] || q_t[i] !== e_t[i]) bad++;
        chk("stream_bases", bad, 0);
        chk("data_idle", 32'({data_s, data_t}), 0);
        chk("busy_wait", 32'(busy), 1);
        chk("done_clear", 32'(done), 0);
        lim = (fin_dly > 0) ? fin_dly : TMO - 1;
        for (int j = 1; j <= lim; j++) begin
            wr_en   = poke && j == 1;
            wr_addr = AW'(5);
            wr_s    = ~m_s[5];
            wr_t    = ~m_t[5];
            start   = poke && j == 2;
            finish  = (j == fin_dly);
            max     = finish ? mx : SW'($urandom);
            @(negedge clk);
        end
        wr_en  = 1'b0;
        start  = 1'b0;
        finish = 1'b0;
        if (fin_dly > 0) begin
            m_result = mx;
            chk("done", 32'(done), 1);
            chk("timeout_clr", 32'(timeout), 0);
`ifdef BSW_STREAM_CHECK_EN
            chk("pass", 32'(pass), 32'(mx == exp_max));
            chk("fail", 32'(fail), 32'(mx != exp_max));
`endif
        end else begin
            chk("timeout_early", 32'(timeout), 0);
            @(negedge clk);
            chk("timeout", 32'(timeout), 1);
            chk("done_tmo", 32'(done), 0);
`ifdef BSW_STREAM_CHECK_EN
            chk("fail_tmo", 32'(fail), 1);
`endif
        end
        chk("result", 32'(result), 32'(m_result));
        chk("busy_end", 32'(busy), 0);
    endtask

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        n_seg    = 0;
        prev_v   = 1'b0;
        m_result = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(i_valid), 0);
        chk("rst_data", 32'({data_s, data_t}), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_timeout", 32'(timeout), 0);
        reset = 1'b1;
        @(negedge clk);

        fill(1'b1);
        run(20, SW'(37), 1'b0, -1);
        run(0, SW'($urandom), 1'b0, -1);

        fill(1'b0);
        run(int'($urandom_range(1, 60)), SW'($urandom), 1'b1, -1);
        run(int'($urandom_range(1, 60)), SW'($urandom), 1'b0, -1);
        run(int'($urandom_range(1, 60)), SW'($urandom), 1'b0, 0);
        run(int'($urandom_range(1, 60)), SW'($urandom), 1'b0,
            int'($urandom_range(1, LEN - 1)));

        // abandon a run halfway through the stream
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (128) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst_valid", 32'(i_valid), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_data", 32'({data_s, data_t}), 0);
        chk("arst_result", 32'(result), 0);
        m_result = '0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run(int'($urandom_range(1, 60)), SW'($urandom), 1'b0, -1);

        run(TMO, SW'($urandom), 1'b0, -1);
        for (int r = 0; r < 3; r++)
            run(int'($urandom_range(1, 60)), SW'($urandom), 1'b0,
                int'($urandom_range(LEN)) - 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
